// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and other Data_memory users.
// Holds the sequencer state encoding, port indices and the round-robin pick rule.
package dmem_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int PORT_CORE = 0;
    localparam int PORT_LOAD = 1;
    localparam int LAT_W     = 2;   // wide enough for latencies 1..3

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Two-way round-robin: a lone requester wins, a tie goes opposite the last winner.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req[0] && req[1]) begin
            return ~last;
        end else if (req[1]) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with a last-winner pointer.
// The pointer only advances when the caller accepts the pick.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       valid,
    output logic       winner
);

    logic last_q;

    assign valid  = |req;
    assign winner = rr_pick(req, last_q);

    // Reset to "load port won last" so the core port wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'(PORT_LOAD);
        end else if (take && valid) begin
            last_q <= winner;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port Data_memory between the core (port 0) and the loader (port 1),
// one access at a time, with registered grants, strobes and per-port read data.
module dmem_arbiter #(
    parameter int ADDR_W  = dmem_pkg::ADDR_W,
    parameter int DATA_W  = dmem_pkg::DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    import dmem_pkg::*;

    state_t            state;
    logic [LAT_W-1:0]  cnt;
    logic              win;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        gnt_q;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              rd_q;
    logic              wr_q;

    logic              arb_valid;
    logic              arb_winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({p1_req, p0_req}),
        .take   (state == IDLE),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        sel_we    = p0_we;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        if (arb_winner == 1'(PORT_LOAD)) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; every register, read-data holders included, has an async reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            win      <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        win               <= arb_winner;
                        we_q              <= sel_we;
                        addr_q            <= sel_addr;
                        wdata_q           <= sel_wdata;
                        gnt_q[arb_winner] <= 1'b1;
                        wr_q              <= sel_we;
                        rd_q              <= ~sel_we;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= LAT_W'(MEM_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - LAT_W'(1);
                    // Last wait cycle: memory data is valid now, capture for the winner only.
                    if (cnt == LAT_W'(1)) begin
                        if (win == 1'(PORT_CORE)) begin
                            rdata0_q <= mem_data_out;
                        end else begin
                            rdata1_q <= mem_data_out;
                        end
                        rvalid_q[win] <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign p0_gnt       = gnt_q[PORT_CORE];
    assign p1_gnt       = gnt_q[PORT_LOAD];
    assign p0_rvalid    = rvalid_q[PORT_CORE];
    assign p1_rvalid    = rvalid_q[PORT_LOAD];
    assign p0_rdata     = rdata0_q;
    assign p1_rdata     = rdata1_q;
    assign mem_address  = addr_q;
    assign mem_data_in  = wdata_q;
    assign mem_MemRead  = rd_q;
    assign mem_MemWrite = wr_q;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a MEM_LAT=1 instance and a MEM_LAT=3 instance,
// each wired to a small behavioural Data_memory model.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        clr;

    logic        p0_req, p0_we, p1_req, p1_we;
    logic [9:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [9:0]  mem_address;
    logic [31:0] mem_data_in, mem_data_out;
    logic        mem_rd, mem_wr, busy;

    logic        t_req;
    logic [9:0]  t_addr;
    logic        t_gnt, t_p1_gnt, t_rvalid, t_p1_rvalid;
    logic [31:0] t_rdata, t_p1_rdata;
    logic [9:0]  t_mem_address;
    logic [31:0] t_mem_data_in, t_mem_data_out;
    logic        t_mem_rd, t_mem_wr, t_busy;

    logic [31:0] mem1 [1024];
    logic [31:0] rd1;
    logic [31:0] mem3 [1024];
    logic [31:0] pipe3 [3];

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.MEM_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_MemRead(mem_rd), .mem_MemWrite(mem_wr),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    dmem_arbiter #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .p0_req(t_req), .p0_we(1'b0), .p0_addr(t_addr), .p0_wdata(32'd0),
        .p1_req(1'b0), .p1_we(1'b0), .p1_addr(10'd0), .p1_wdata(32'd0),
        .p0_gnt(t_gnt), .p1_gnt(t_p1_gnt), .p0_rvalid(t_rvalid), .p1_rvalid(t_p1_rvalid),
        .p0_rdata(t_rdata), .p1_rdata(t_p1_rdata),
        .mem_address(t_mem_address), .mem_data_in(t_mem_data_in),
        .mem_MemRead(t_mem_rd), .mem_MemWrite(t_mem_wr),
        .mem_data_out(t_mem_data_out), .busy(t_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data_memory model, one-cycle read latency.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= 32'd0;
            rd1 <= 32'd0;
        end else begin
            if (mem_wr) mem1[mem_address] <= mem_data_in;
            if (mem_rd) rd1 <= mem1[mem_address];
        end
    end
    assign mem_data_out = rd1;

    // Data_memory model, three-cycle read latency, address 12 preloaded.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem3[i] <= 32'd0;
            mem3[12] <= 32'hCAFE_1234;
            for (int i = 0; i < 3; i++) pipe3[i] <= 32'd0;
        end else begin
            if (t_mem_wr) mem3[t_mem_address] <= t_mem_data_in;
            pipe3[0] <= t_mem_rd ? mem3[t_mem_address] : 32'd0;
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end
    assign t_mem_data_out = pipe3[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) step();
        check("idle_timeout", busy, 0);
    endtask

    initial begin
        int ngr, nrv, cur, n;
        logic saw_gnt, saw_addr, saw_rv;

        rst = 1'b0; clr = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        t_req = 0; t_addr = 0;
        step(); step();
        clr = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_gnt", {p0_gnt, p1_gnt}, 0);
        check("rst_strobes", {mem_rd, mem_wr}, 0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_mem_din", mem_data_in, 0);
        rst = 1'b1;
        step();

        // Port 0 write addr 9 data 748.
        p0_req = 1; p0_we = 1; p0_addr = 10'd9; p0_wdata = 32'd748;
        step();
        check("wr_p0_gnt", p0_gnt, 1);
        check("wr_p1_gnt", p1_gnt, 0);
        check("wr_strobe", {mem_wr, mem_rd}, 2'b10);
        check("wr_addr", mem_address, 9);
        check("wr_data", mem_data_in, 748);
        check("wr_busy", busy, 1);
        p0_req = 0;
        step();
        check("wr_gnt_pulse", p0_gnt, 0);
        check("wr_strobe_off", {mem_wr, mem_rd}, 0);
        check("wr_busy_low", busy, 0);
        check("wr_addr_hold", mem_address, 9);
        check("wr_landed", mem1[9], 748);

        // Port 1 read addr 9.
        p1_req = 1; p1_we = 0; p1_addr = 10'd9;
        step();
        check("rd_p1_gnt", p1_gnt, 1);
        check("rd_strobe", {mem_wr, mem_rd}, 2'b01);
        p1_req = 0;
        step();
        check("rd_wait_rvalid", p1_rvalid, 0);
        check("rd_wait_busy", busy, 1);
        step();
        check("rd_rvalid", p1_rvalid, 1);
        check("rd_p1_rdata", p1_rdata, 748);
        check("rd_p0_rdata", p0_rdata, 0);
        check("rd_p0_rvalid", p0_rvalid, 0);
        step();
        check("rd_rvalid_pulse", p1_rvalid, 0);
        check("rd_idle", busy, 0);
        check("rd_rdata_hold", p1_rdata, 748);

        // Both ports request continuously.
        p0_req = 1; p0_we = 0; p0_addr = 10'd0;
        p1_req = 1; p1_we = 1; p1_addr = 10'd0; p1_wdata = 32'd2;
        ngr = 0; nrv = 0;
        for (int c = 1; c <= 14; c++) begin
            step();
            check("rr_one_gnt", p0_gnt & p1_gnt, 0);
            check("rr_strobe_excl", mem_rd & mem_wr, 0);
            if (p0_gnt || p1_gnt) begin
                cur = p1_gnt ? 1 : 0;
                check("rr_alternate", cur, ngr % 2);
                ngr++;
            end
            if (p0_rvalid) begin
                check("rr_p0_rdata", p0_rdata, (nrv == 0) ? 0 : 2);
                nrv++;
            end
        end
        check("rr_grant_count", ngr, 5);
        check("rr_rvalid_count", nrv, 2);
        p0_req = 0; p1_req = 0;
        wait_idle();
        step();

        // Port 0 blips a request while port 1 reads.
        p1_req = 1; p1_we = 0; p1_addr = 10'd9;
        step();
        check("blip_p1_gnt", p1_gnt, 1);
        p1_req = 0;
        p0_req = 1; p0_we = 1; p0_addr = 10'd77; p0_wdata = 32'h77;
        step();
        p0_req = 0;
        saw_gnt = p0_gnt; saw_addr = 0; saw_rv = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            saw_gnt  |= p0_gnt;
            saw_addr |= (mem_rd | mem_wr) && (mem_address == 10'd77);
            if (p1_rvalid) begin
                saw_rv = 1;
                check("blip_p1_rdata", p1_rdata, 748);
            end
        end
        check("blip_no_p0_gnt", saw_gnt, 0);
        check("blip_no_access", saw_addr, 0);
        check("blip_mem77", mem1[77], 0);
        check("blip_p1_served", saw_rv, 1);
        check("blip_p0_rdata", p0_rdata, 2);

        // Reset during WAIT of a port 0 read.
        p0_req = 1; p0_we = 0; p0_addr = 10'd9;
        step();
        check("mid_p0_gnt", p0_gnt, 1);
        p0_req = 0;
        step();
        check("mid_in_wait", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rdata", {p0_rdata, p1_rdata}, 0);
        check("mid_rst_outs", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_rd, mem_wr}, 0);
        check("mid_rst_mem", {mem_address, mem_data_in}, 0);
        step();
        rst = 1'b1;
        saw_rv = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            saw_rv |= p0_rvalid | p1_rvalid;
        end
        check("mid_no_rvalid", saw_rv, 0);
        p0_req = 1; p0_we = 0; p0_addr = 10'd9;
        p1_req = 1; p1_we = 1; p1_addr = 10'd3; p1_wdata = 32'h33;
        step();
        check("tie_p0_wins", {p1_gnt, p0_gnt}, 2'b01);
        p0_req = 0;
        saw_gnt = 0;
        for (int c = 0; c < 10 && !saw_gnt; c++) begin
            step();
            saw_gnt = p1_gnt;
        end
        check("tie_p1_served", saw_gnt, 1);
        p1_req = 0;
        step();
        check("tie_p1_write", mem1[3], 32'h33);
        wait_idle();

        // MEM_LAT = 3 instance: read addr 12.
        t_req = 1; t_addr = 10'd12;
        n = 0;
        while (n < 10) begin
            step();
            n++;
            if (t_gnt) t_req = 0;
            if (t_rvalid) break;
        end
        check("lat3_rvalid_cycle", n, 5);
        check("lat3_rdata", t_rdata, 32'hCAFE_1234);
        check("lat3_rvalid", t_rvalid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port `Data_memory` (10-bit word address, 32-bit data, `MemRead`/`MemWrite` strobes).
- Shares the memory between the core load/store stage (port 0) and the program/debug loader (port 1).
- Serialises accesses with round-robin fairness and drives the memory strobes for exactly one cycle per access.
- Returns registered read data with a valid pulse to the requester that issued the read.

## Interface
Parameters:
- `ADDR_W`, 10, memory word-address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, cycles from strobe cycle to valid `mem_data_out` (range 1–3)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `p0_req`, `p1_req`  in  1  access request; requester holds it and its fields stable until `pX_gnt`
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read
- `p0_addr`, `p1_addr`  in  ADDR_W  word address
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data
- `p0_gnt`, `p1_gnt`  out  1  one-cycle pulse: request accepted, fields latched
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle pulse: `pX_rdata` holds read result
- `p0_rdata`, `p1_rdata`  out  DATA_W  read data, held until that port's next `rvalid`
- `mem_address`  out  ADDR_W  to `Data_memory.address`
- `mem_data_in`  out  DATA_W  to `Data_memory.data_in`
- `mem_MemRead`, `mem_MemWrite`  out  1  memory strobes, mutually exclusive
- `mem_data_out`  in  DATA_W  from `Data_memory.data_out`
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: if any `req`, pick winner, latch `we`/`addr`/`wdata`, pulse winner `gnt`, go to ISSUE.
  - ISSUE: drive strobe from latched `we` for one cycle. Write goes to IDLE; read goes to WAIT, loading counter with `MEM_LAT`.
  - WAIT: decrement counter; at 0 capture `mem_data_out` into winner's `rdata`, go to RESP.
  - RESP: winner's `rvalid` high, go to IDLE.
- Arbitration is round-robin with a last-winner pointer.
  - Pointer resets to "port 1 last", so port 0 wins the first tie.
  - A single requester always wins.
  - Pointer updates only on grant.
- Requests are not queued. Dropping `req` before `gnt` is legal and leaves no side effects. `req` seen in the `gnt` cycle is a new request.
- `mem_address`/`mem_data_in` hold the latched values outside ISSUE; strobes are 0 outside ISSUE.
- Port data paths are independent: `rdata` of the non-winning port never changes.

## Timing
- Reset (asynchronous, immediate): all `gnt`/`rvalid`/strobes 0, `rdata` 0, `mem_address` 0, `mem_data_in` 0, `busy` 0, state IDLE, pointer as above.
  - Mid-access reset drops the access; no `rvalid` follows.
  - A write in ISSUE whose strobe is cut by reset is not guaranteed to land.
- `req` high in cycle N (IDLE):
  - `gnt` and strobe in cycle N+1.
  - Write: `busy` low N+2, next `gnt` earliest N+3.
  - Read: `rvalid` in N+2+`MEM_LAT` (N+3 at default), IDLE in N+3+`MEM_LAT`.
- Throughput: write one per 2 cycles; read one per 3+`MEM_LAT` cycles.
- Worst-case wait for a continuously asserted request is one access of the other port.
- Simultaneous `req` in IDLE: grant opposite of pointer; exactly one `gnt` per cycle, never both.

## Structure
- Shared package `dmem_pkg`:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - port index constants `PORT_CORE`=0, `PORT_LOAD`=1
  - `ADDR_W`/`DATA_W` defaults, shared with `Data_memory` users
- Sub-module `rr_arb2`: combinational two-way round-robin pick plus pointer register. Everything else in `dmem_arbiter`.

## Test plan
- Reset then port 0 write addr 9 data 748 → `p0_gnt` one cycle later, `mem_MemWrite`=1 with address 9/data 748 for one cycle, `busy` low after 2 cycles.
- Port 1 read addr 9 after that write → `p1_rvalid` 3 cycles after `req`, `p1_rdata`=748, `p0_rdata` unchanged.
- Both ports request continuously (p0 read addr 0, p1 write addr 0 data 2) → grants alternate p0,p1,p0…, never both in one cycle; strobes never both high.
- Port 0 raises `req` for one cycle while port 1 access in progress, then drops it → no `p0_gnt`, no memory access at port 0's address.
- `rst` low during WAIT of a read → outputs zero immediately, no `rvalid` after release, next request serviced normally with port 0 winning a tie.
- `MEM_LAT`=3 build: read addr 12 → `rvalid` exactly 5 cycles after `req`, data matches preloaded memory.
